// File: rtl/sccb_cfg_master_pkg.sv
// sccb_cfg_master_pkg: shared FSM states and SCCB frame constants for the camera configurator
package sccb_cfg_master_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_START, S_BITS, S_STOP, S_GAP, S_FIN} state_t;
  localparam logic [15:0] SCCB_END_MARK = 16'hFFFF;
  localparam int SCCB_BITS = 27;
endpackage

// File: rtl/sccb_qtick.sv
// sccb_qtick: quarter-bit tick generator; clk/rst/clr in, qtick pulses once every QDIV cycles while clr is low
module sccb_qtick #(
  parameter int QDIV = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic qtick
);
  localparam int W = QDIV > 1 ? $clog2(QDIV) : 1;
  logic [W-1:0] cnt;
  assign qtick = ~clr & (cnt == W'(QDIV - 1));
  always_ff @(posedge clk) cnt <= (rst || clr || qtick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/sccb_cfg_master.sv
// sccb_cfg_master: walks a {reg,val} ROM and writes each entry over SCCB; ports clk_100m/rst/start in, rom_idx out, rom_data in, sioc/siod_oe/busy/done out
module sccb_cfg_master
  import sccb_cfg_master_pkg::*;
#(
  parameter int          CLK_HZ   = 100_000_000,
  parameter int          SCCB_HZ  = 100_000,
  parameter logic [7:0]  DEV_ADDR = 8'h42,
  parameter int          GAP_CYC  = 1000,
  parameter int          IDX_W    = 8
) (
  input  logic             clk_100m,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] rom_idx,
  input  logic [15:0]      rom_data,
  output logic             sioc,
  output logic             siod_oe,
  output logic             busy,
  output logic             done
);
  localparam int QDIV = CLK_HZ / (4 * SCCB_HZ);
  localparam int GW = $clog2(GAP_CYC + 1);
  state_t               state;
  logic [1:0]           q;
  logic [4:0]           bit_cnt;
  logic [SCCB_BITS-1:0] sr;
  logic [GW-1:0]        gap_cnt;
  logic                 fwait;
  logic                 last;
  logic                 qtick;
  logic                 tick_clr;
  logic                 is_end;
  assign tick_clr = state == S_IDLE || state == S_GAP || state == S_FIN;
  assign is_end = rom_data == SCCB_END_MARK;
  sccb_qtick #(.QDIV(QDIV)) u_qtick (
    .clk   (clk_100m),
    .rst   (rst),
    .clr   (tick_clr),
    .qtick (qtick)
  );
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      state   <= S_IDLE;
      q       <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      gap_cnt <= '0;
      fwait   <= 1'b0;
      last    <= 1'b0;
      rom_idx <= '0;
      sioc    <= 1'b1;
      siod_oe <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          busy    <= 1'b1;
          rom_idx <= '0;
          fwait   <= 1'b0;
          state   <= S_FETCH;
        end
        S_FETCH: begin
          fwait <= ~fwait;
          if (fwait) begin
            sr    <= {DEV_ADDR, 1'b1, rom_data[15:8], 1'b1, rom_data[7:0], 1'b1};
            q     <= '0;
            state <= is_end ? S_FIN : S_START;
            done  <= is_end;
            busy  <= ~is_end;
          end
        end
        S_START: if (qtick) begin
          q <= q + 1'b1;
          if (q == 2'd0) siod_oe <= 1'b1;
          if (q == 2'd1) sioc <= 1'b0;
          if (q == 2'd3) begin
            state   <= S_BITS;
            bit_cnt <= '0;
            siod_oe <= ~sr[SCCB_BITS-1];
          end
        end
        S_BITS: if (qtick) begin
          q <= q + 1'b1;
          if (q == 2'd1) sioc <= 1'b1;
          if (q == 2'd3) begin
            sioc <= 1'b0;
            if (bit_cnt == 5'(SCCB_BITS - 1)) begin
              state   <= S_STOP;
              siod_oe <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sr      <= {sr[SCCB_BITS-2:0], 1'b0};
              siod_oe <= ~sr[SCCB_BITS-2];
            end
          end
        end
        S_STOP: if (qtick) begin
          q <= q + 1'b1;
          if (q == 2'd0) sioc <= 1'b1;
          if (q == 2'd1) siod_oe <= 1'b0;
          if (q == 2'd3) begin
            state   <= S_GAP;
            gap_cnt <= '0;
            // the top table slot is final: finish instead of wrapping to 0
            last    <= &rom_idx;
            if (~&rom_idx) rom_idx <= rom_idx + 1'b1;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GW'(GAP_CYC - 1)) begin
            fwait <= 1'b0;
            state <= last ? S_FIN : S_FETCH;
            done  <= last;
            busy  <= ~last;
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
